// File: rtl/inst_seq_gen.sv
// Instruction-cycle sequencer: one-hot T-state generator with opcode-fetch sync,
// RDY stall, overrun detection and per-instruction length/count statistics.
module inst_seq_gen #(
  parameter int CYCLES = 6,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              next_sync,
  input  logic              err_clr,
  output logic [CYCLES-1:0] cycle,
  output logic [IDX_W-1:0]  cycle_idx,
  output logic              sync,
  output logic              running,
  output logic              overrun,
  output logic [IDX_W-1:0]  last_len,
  output logic [CNT_W-1:0]  inst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state_q;
  logic [CYCLES-1:0]  cycle_q;
  logic [IDX_W-1:0]   idx_q;
  logic               sync_q;
  logic               overrun_q;
  logic [IDX_W-1:0]   last_len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               overrun_set_d;

  // An overrun is the shift that would push the one-hot bit past the top.
  assign overrun_set_d = ready && !next_sync && (state_q == RUN) && cycle_q[CYCLES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cycle_q    <= '0;
      idx_q      <= '0;
      sync_q     <= 1'b0;
      overrun_q  <= 1'b0;
      last_len_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (overrun_set_d) begin
        overrun_q <= 1'b1;
      end else if (err_clr) begin
        overrun_q <= 1'b0;
      end

      if (ready) begin
        if (next_sync) begin
          if (state_q == RUN) begin
            last_len_q <= idx_q;
          end
          cycle_q <= CYCLES'(1);
          idx_q   <= IDX_W'(1);
          sync_q  <= 1'b1;
          state_q <= RUN;
          cnt_q   <= cnt_q + CNT_W'(1);
        end else begin
          sync_q <= 1'b0;
          case (state_q)
            RUN: begin
              if (cycle_q[CYCLES-1]) begin
                cycle_q <= '0;
                idx_q   <= '0;
                state_q <= HALT;
              end else begin
                cycle_q <= {cycle_q[CYCLES-2:0], 1'b0};
                idx_q   <= idx_q + IDX_W'(1);
              end
            end
            IDLE, HALT: begin
              cycle_q <= '0;
              idx_q   <= '0;
            end
            default: begin
              cycle_q <= '0;
              idx_q   <= '0;
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign cycle     = cycle_q;
  assign cycle_idx = idx_q;
  assign sync      = sync_q;
  assign running   = (state_q == RUN);
  assign overrun   = overrun_q;
  assign last_len  = last_len_q;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_seq_gen.sv
// Self-checking bench for inst_seq_gen: directed vector table, hand-written
// corner sequences and randomized traffic against a position-based model.
module tb_inst_seq_gen;

  localparam int CYCLES = 6;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              ready;
  logic              next_sync;
  logic              err_clr;
  logic [CYCLES-1:0] cycle;
  logic [IDX_W-1:0]  cycle_idx;
  logic              sync;
  logic              running;
  logic              overrun;
  logic [IDX_W-1:0]  last_len;
  logic [CNT_W-1:0]  inst_cnt;

  int checks = 0;
  int errors = 0;

  inst_seq_gen #(.CYCLES(CYCLES), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .next_sync (next_sync),
    .err_clr   (err_clr),
    .cycle     (cycle),
    .cycle_idx (cycle_idx),
    .sync      (sync),
    .running   (running),
    .overrun   (overrun),
    .last_len  (last_len),
    .inst_cnt  (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rdy;
    logic              ns;
    logic              ec;
    logic [CYCLES-1:0] expCycle;
    logic [IDX_W-1:0]  expIdx;
    logic              expSync;
    logic              expRun;
    logic              expOv;
    logic [IDX_W-1:0]  expLen;
    logic [CNT_W-1:0]  expCnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: pos is the 1-based T-state, 0 when not running.
  int   mPos;
  logic mSync;
  logic mOv;
  int   mLen;
  int   mCnt;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [CYCLES-1:0] eCycle,
                             input logic [IDX_W-1:0] eIdx, input logic eSync,
                             input logic eRun, input logic eOv,
                             input logic [IDX_W-1:0] eLen, input logic [CNT_W-1:0] eCnt);
    cmp({tag, ".cycle"},     int'(cycle),     int'(eCycle));
    cmp({tag, ".cycle_idx"}, int'(cycle_idx), int'(eIdx));
    cmp({tag, ".sync"},      int'(sync),      int'(eSync));
    cmp({tag, ".running"},   int'(running),   int'(eRun));
    cmp({tag, ".overrun"},   int'(overrun),   int'(eOv));
    cmp({tag, ".last_len"},  int'(last_len),  int'(eLen));
    cmp({tag, ".inst_cnt"},  int'(inst_cnt),  int'(eCnt));
  endtask

  // Drive one cycle's inputs, clock once, and leave sampling 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic ns, input logic ec);
    ready     = r;
    next_sync = ns;
    err_clr   = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    ready = 1'b1; next_sync = 1'b0; err_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mPos = 0; mSync = 1'b0; mOv = 1'b0; mLen = 0; mCnt = 0;
  endtask

  // Advance the model by one edge from the rules, not the RTL structure.
  task automatic modelStep(input logic r, input logic ns, input logic ec);
    logic ovSet;
    ovSet = 1'b0;
    if (r) begin
      if (ns) begin
        if (mPos != 0) mLen = mPos;
        mPos  = 1;
        mSync = 1'b1;
        mCnt  = (mCnt + 1) % (1 << CNT_W);
      end else begin
        mSync = 1'b0;
        if (mPos == CYCLES) begin
          mPos  = 0;
          ovSet = 1'b1;
        end else if (mPos != 0) begin
          mPos = mPos + 1;
        end
      end
    end
    if (ovSet) mOv = 1'b1;
    else if (ec) mOv = 1'b0;
  endtask

  function automatic logic [CYCLES-1:0] posToOneHot(input int p);
    logic [CYCLES-1:0] one;
    one = CYCLES'(1);
    return (p == 0) ? '0 : (one << (p - 1));
  endfunction

  initial begin
    rst = 1'b0; ready = 1'b0; next_sync = 1'b0; err_clr = 1'b0;
    #2;

    // Directed table: fetch, stall with ignored request, overrun, HALT restart.
    vecs.push_back('{1'b1, 1'b1, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000010, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000100, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000010, 3'd2, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000100, 3'd3, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 6'b000100, 3'd3, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b000100, 3'd3, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b001000, 3'd4, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b010000, 3'd5, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b100000, 3'd6, 1'b0, 1'b1, 1'b0, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd2});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b1, 1'b1, 3'd3, 4'd3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 4'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b000001, 3'd1, 1'b1, 1'b1, 1'b0, 3'd1, 4'd4});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 6'b000010, 3'd2, 1'b0, 1'b1, 1'b0, 3'd1, 4'd4});

    doReset();
    checkOutput("reset", '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].ns, vecs[i].ec);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCycle, vecs[i].expIdx, vecs[i].expSync,
                  vecs[i].expRun, vecs[i].expOv, vecs[i].expLen, vecs[i].expCnt);
    end

    // Overrun and err_clr on the same edge: the set must win.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < CYCLES - 1; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ovSetWins", '0, '0, 1'b0, 1'b0, 1'b1, '0, 4'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ovCleared", '0, '0, 1'b0, 1'b0, 1'b0, '0, 4'd1);

    // Asynchronous reset between edges mid-instruction.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("preRst", 6'b001000, 3'd4, 1'b0, 1'b1, 1'b0, 3'd1, 4'd9);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst", '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idleAfterRst", '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Counter wrap: 17 starts on a 4-bit counter.
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("cntWrap", 6'b000001, 3'd1, 1'b1, 1'b1, 1'b0, 3'd1, 4'd1);

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 2000; n++) begin
      logic r, ns, ec;
      r  = ($urandom_range(0, 4) != 0);
      ns = ($urandom_range(0, 5) == 0);
      ec = ($urandom_range(0, 14) == 0);
      applyStimulus(r, ns, ec);
      modelStep(r, ns, ec);
      checkOutput($sformatf("rand%0d", n), posToOneHot(mPos), IDX_W'(mPos), mSync,
                  (mPos != 0), mOv, IDX_W'(mLen), CNT_W'(mCnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
